// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit-timing counter width; cnt runs 0..clks_per_bit-1.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: pop_data presents the head entry whenever empty is low.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Pointer MSB acts as a lap bit: equal low bits with differing MSB means full.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[PW-1] != rptr[PW-1]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop synchroniser, majority-vote bit sampling, framing FSM
// and an output FIFO carrying {frame_err, parity_err, data} per frame.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);

  localparam int CW    = cnt_width(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int FW    = DATA_BITS + 2;

  localparam logic [CW-1:0]    C_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    C_HM1    = CW'(H - 1);
  localparam logic [CW-1:0]    C_H      = CW'(H);
  localparam logic [CW-1:0]    C_HP1    = CW'(H + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_meta, rxs;

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [1:0]           samp, samp_n;
  logic                 maj, maj_q, maj_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 stop2, stop2_n;
  logic                 exp_par;

  logic                 push;
  logic [FW-1:0]        push_data;
  logic                 pop;
  logic [FW-1:0]        head;
  logic                 fifo_full, fifo_empty;
  logic                 ovr_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rxs     <= rx_meta;
    end
  end

  // Vote over the samples taken at H-1, H and the live value at H+1.
  assign maj = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

  assign exp_par = (PARITY == PAR_EVEN) ? ^shreg :
                   (PARITY == PAR_ODD)  ? ~^shreg : 1'b0;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      samp  <= 2'b11;
      maj_q <= 1'b1;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      stop2 <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      samp  <= samp_n;
      maj_q <= maj_n;
      shreg <= shreg_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      stop2 <= stop2_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    samp_n    = samp;
    maj_n     = maj_q;
    shreg_n   = shreg;
    perr_n    = perr;
    ferr_n    = ferr;
    stop2_n   = stop2;
    push      = 1'b0;
    push_data = {ferr | ~maj, perr, shreg};

    if (cnt == C_HM1) samp_n[0] = rxs;
    if (cnt == C_H)   samp_n[1] = rxs;
    if (cnt == C_HP1) maj_n     = maj;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rxs) begin
          state_n = S_START;
          cnt_n   = CW'(1);
        end
      end
      S_START: begin
        cnt_n = cnt + CW'(1);
        if (cnt == C_HP1 && maj) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == C_LAST) begin
          state_n = S_DATA;
          cnt_n   = '0;
          idx_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          stop2_n = 1'b0;
        end
      end
      S_DATA: begin
        cnt_n = cnt + CW'(1);
        if (cnt == C_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = maj_q;
          if (idx == IDX_LAST) begin
            state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        cnt_n = cnt + CW'(1);
        if (cnt == C_LAST) begin
          cnt_n   = '0;
          state_n = S_STOP;
          if (maj_q != exp_par) perr_n = 1'b1;
        end
      end
      S_STOP: begin
        cnt_n = cnt + CW'(1);
        // The last stop bit finishes at H+1 so a back-to-back start edge is seen.
        if (cnt == C_HP1 && (STOP_BITS == 1 || stop2)) begin
          push    = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == C_LAST) begin
          cnt_n   = '0;
          stop2_n = 1'b1;
          ferr_n  = ferr | ~maj_q;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Handshake: an entry transfers on a rising edge where o_Rx_Valid and
  // i_Rx_Ready are both high; o_Rx_Valid never drops without a transfer.
  assign pop = !fifo_empty && i_Rx_Ready;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) ovr_q <= 1'b0;
    else         ovr_q <= push && fifo_full && !pop;
  end

  assign o_Rx_Valid   = !fifo_empty;
  assign o_Rx_Data    = head[DATA_BITS-1:0];
  assign o_Parity_Err = head[DATA_BITS];
  assign o_Frame_Err  = head[DATA_BITS+1];
  assign o_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations driven by a serial frame
// generator and checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int CPB     = 16;
  localparam int H       = CPB / 2;
  localparam int DEPTH_A = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a, rdy_b, rdy_c;
  logic val_a, val_b, val_c;
  logic [7:0] dat_a;
  logic [6:0] dat_b;
  logic [8:0] dat_c;
  logic perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c, ovr_a, ovr_b, ovr_c;

  // A: 8 bits even parity 1 stop depth 2; B: 7 bits odd 2 stops; C: 9 bits no parity
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_Valid(val_a), .i_Rx_Ready(rdy_a),
    .o_Rx_Data(dat_a), .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Overrun(ovr_a));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_Valid(val_b), .i_Rx_Ready(rdy_b),
    .o_Rx_Data(dat_b), .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Overrun(ovr_b));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_Valid(val_c), .i_Rx_Ready(rdy_c),
    .o_Rx_Data(dat_c), .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Overrun(ovr_c));

  int nbits   [3] = '{8, 7, 9};
  int par_cfg [3] = '{2, 1, 0};
  int nstop   [3] = '{1, 2, 1};

  logic [10:0] exp_q[$];
  logic [10:0] got_a[$], got_b[$], got_c[$];
  int ovr_cnt [3] = '{0, 0, 0};
  int ovr_cyc = -1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // scoreboard capture: entries as {frame_err, parity_err, data zero-extended to 9}
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst) begin
      if (val_a && rdy_a) got_a.push_back({ferr_a, perr_a, 1'b0, dat_a});
      if (val_b && rdy_b) got_b.push_back({ferr_b, perr_b, 2'b00, dat_b});
      if (val_c && rdy_c) got_c.push_back({ferr_c, perr_c, dat_c});
      if (ovr_a) begin ovr_cnt[0]++; ovr_cyc = cyc; end
      if (ovr_b) ovr_cnt[1]++;
      if (ovr_c) ovr_cnt[2]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: the entry a frame should produce
  function automatic logic [10:0] model_entry(input int inst, input logic [8:0] d,
                                              input bit par_bad, input logic [1:0] stop_mask);
    logic [8:0] m;
    logic fe;
    m  = d & ((9'd1 << nbits[inst]) - 9'd1);
    fe = stop_mask[0] | ((nstop[inst] == 2) && stop_mask[1]);
    return {fe, (par_cfg[inst] != 0) && par_bad, m};
  endfunction

  function automatic int got_size(input int inst);
    case (inst)
      0:       return got_a.size();
      1:       return got_b.size();
      default: return got_c.size();
    endcase
  endfunction

  function automatic logic [10:0] pop_got(input int inst);
    logic [10:0] v = 'x;
    case (inst)
      0:       if (got_a.size() > 0) v = got_a.pop_front();
      1:       if (got_b.size() > 0) v = got_b.pop_front();
      default: if (got_c.size() > 0) v = got_c.pop_front();
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_frame(input int inst, input logic [8:0] d, input bit par_bad,
                            input logic [1:0] stop_mask, input logic [8:0] glitch_mask,
                            input int glitch_cyc, input int gap);
    logic bits[$];
    int ones = 0;
    int g = gap;
    logic gl;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits[inst]; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_cfg[inst] == 2) bits.push_back(((ones % 2) == 1) ^ par_bad);
    else if (par_cfg[inst] == 1) bits.push_back(((ones % 2) == 0) ^ par_bad);
    for (int s = 0; s < nstop[inst]; s++) bits.push_back(!stop_mask[s]);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        gl = (b >= 1) && (b <= nbits[inst]) && glitch_mask[b-1] && (c == glitch_cyc);
        set_line(inst, gl ? ~bits[b] : bits[b]);
      end
    end
    if (stop_mask != 2'b00 && g < 20) g = 20;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      set_line(inst, 1'b1);
    end
  endtask

  task automatic wait_got(input int inst, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (got_size(inst) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({val_a, dat_a, perr_a, ferr_a, ovr_a} !== '0) begin
      fails++; $display("FAIL reset_outputs_a: got %h, required 0", {val_a, dat_a, perr_a, ferr_a, ovr_a});
    end
    tests++;
    if ({val_b, dat_b, perr_b, ferr_b, ovr_b} !== '0) begin
      fails++; $display("FAIL reset_outputs_b: got %h, required 0", {val_b, dat_b, perr_b, ferr_b, ovr_b});
    end
    tests++;
    if ({val_c, dat_c, perr_c, ferr_c, ovr_c} !== '0) begin
      fails++; $display("FAIL reset_outputs_c: got %h, required 0", {val_c, dat_c, perr_c, ferr_c, ovr_c});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if ({val_a, val_b, val_c} !== 3'b000) begin
      fails++; $display("FAIL idle_after_reset: valid %b, required 000", {val_a, val_b, val_c});
    end
  endtask

  task automatic test_parity();
    logic [10:0] e, g;
    bit ok;
    exp_q.delete();
    exp_q.push_back(model_entry(0, 9'h0A5, 1'b0, 2'b00));
    send_frame(0, 9'h0A5, 1'b0, 2'b00, 9'h000, 0, 5);
    exp_q.push_back(model_entry(0, 9'h0A5, 1'b1, 2'b00));
    send_frame(0, 9'h0A5, 1'b1, 2'b00, 9'h000, 0, 5);
    exp_q.push_back(model_entry(0, 9'h03C, 1'b0, 2'b01));
    send_frame(0, 9'h03C, 1'b0, 2'b01, 9'h000, 0, 20);
    exp_q.push_back(model_entry(0, 9'h000, 1'b0, 2'b01));
    send_frame(0, 9'h000, 1'b0, 2'b01, 9'h000, 0, 20);
    wait_got(0, 4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL parity_timeout: got %0d entries, required 4", got_size(0)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = pop_got(0);
      tests++;
      if (g !== e) begin fails++; $display("FAIL parity_entry: got %h, required %h", g, e); end
    end
    repeat (10) @(negedge clk);
    tests++;
    if (got_size(0) != 0) begin fails++; $display("FAIL parity_extra: got %0d extra entries, required 0", got_size(0)); end
  endtask

  task automatic test_glitch();
    logic [10:0] e, g;
    bit ok;
    exp_q.delete();
    exp_q.push_back(model_entry(1, 9'h055, 1'b0, 2'b00));
    send_frame(1, 9'h055, 1'b0, 2'b00, 9'b000001001, H, 5);
    exp_q.push_back(model_entry(1, 9'h02A, 1'b0, 2'b00));
    send_frame(1, 9'h02A, 1'b0, 2'b00, 9'b001000010, H - 1, 5);
    // 4-cycle low pulse on the idle line must be rejected as a false start
    for (int i = 0; i < 4; i++) begin @(negedge clk); set_line(1, 1'b0); end
    @(negedge clk);
    set_line(1, 1'b1);
    repeat (80) @(negedge clk);
    wait_got(1, 2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL glitch_timeout: got %0d entries, required 2", got_size(1)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = pop_got(1);
      tests++;
      if (g !== e) begin fails++; $display("FAIL glitch_entry: got %h, required %h", g, e); end
    end
    tests++;
    if (got_size(1) != 0 || val_b !== 1'b0) begin
      fails++; $display("FAIL false_start: got %0d entries valid %b, required 0 entries valid 0", got_size(1), val_b);
    end
  endtask

  task automatic test_overrun();
    logic [10:0] e, g;
    bit ok;
    int exp_ovr = 0;
    int start3 = 0;
    exp_q.delete();
    @(negedge clk);
    rdy_a = 1'b0;
    ovr_cnt[0] = 0;
    ovr_cyc = -1;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) start3 = cyc;
      if (exp_q.size() < DEPTH_A) exp_q.push_back(model_entry(0, 9'(i), 1'b0, 2'b00));
      else exp_ovr++;
      send_frame(0, 9'(i), 1'b0, 2'b00, 9'h000, 0, 0);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (ovr_cnt[0] != exp_ovr) begin fails++; $display("FAIL overrun_count: got %0d pulses, required %0d", ovr_cnt[0], exp_ovr); end
    tests++;
    if (ovr_cyc <= start3) begin fails++; $display("FAIL overrun_time: pulse at cycle %0d, required after %0d", ovr_cyc, start3); end
    tests++;
    if ({val_a, dat_a} !== {1'b1, exp_q[0][7:0]}) begin
      fails++; $display("FAIL overrun_head: got %h, required %h", {val_a, dat_a}, {1'b1, exp_q[0][7:0]});
    end
    @(negedge clk);
    rdy_a = 1'b1;
    wait_got(0, 2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL overrun_timeout: got %0d entries, required 2", got_size(0)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = pop_got(0);
      tests++;
      if (g !== e) begin fails++; $display("FAIL overrun_entry: got %h, required %h", g, e); end
    end
    repeat (5) @(negedge clk);
    tests++;
    if (val_a !== 1'b0 || got_size(0) != 0) begin
      fails++; $display("FAIL overrun_drain: valid %b entries %0d, required 0 and 0", val_a, got_size(0));
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] e, g;
    bit ok;
    exp_q.delete();
    @(negedge clk);
    rdy_a = 1'b0;
    send_frame(0, 9'h033, 1'b0, 2'b00, 9'h000, 0, 5);
    repeat (5) @(negedge clk);
    tests++;
    if (val_a !== 1'b1) begin fails++; $display("FAIL midreset_queued: valid %b, required 1", val_a); end
    // partial 0xFF: start bit, data bits 0..3, then half of bit 4
    for (int c = 0; c < CPB; c++) begin @(negedge clk); set_line(0, 1'b0); end
    for (int c = 0; c < 4 * CPB + H; c++) begin @(negedge clk); set_line(0, 1'b1); end
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({val_a, dat_a, perr_a, ferr_a, ovr_a} !== '0) begin
      fails++; $display("FAIL midreset_async: got %h, required 0", {val_a, dat_a, perr_a, ferr_a, ovr_a});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (val_a !== 1'b0) begin fails++; $display("FAIL midreset_empty: valid %b, required 0", val_a); end
    rdy_a = 1'b1;
    exp_q.push_back(model_entry(0, 9'h081, 1'b0, 2'b00));
    send_frame(0, 9'h081, 1'b0, 2'b00, 9'h000, 0, 5);
    wait_got(0, 1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midreset_timeout: got %0d entries, required 1", got_size(0)); end
    e = exp_q.pop_front();
    g = pop_got(0);
    tests++;
    if (g !== e) begin fails++; $display("FAIL midreset_entry: got %h, required %h", g, e); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e, g;
    bit ok;
    exp_q.delete();
    exp_q.push_back(model_entry(2, 9'h1F0, 1'b0, 2'b00));
    send_frame(2, 9'h1F0, 1'b0, 2'b00, 9'h000, 0, 0);
    exp_q.push_back(model_entry(2, 9'h00F, 1'b0, 2'b00));
    send_frame(2, 9'h00F, 1'b0, 2'b00, 9'h000, 0, 5);
    wait_got(2, 2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: got %0d entries, required 2", got_size(2)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = pop_got(2);
      tests++;
      if (g !== e) begin fails++; $display("FAIL b2b_entry: got %h, required %h", g, e); end
    end
  endtask

  task automatic test_random();
    logic [10:0] e, g;
    logic [8:0] d, gm;
    logic [1:0] sm;
    bit pb, ok;
    int gc;
    for (int inst = 0; inst < 3; inst++) begin
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
        d  = 9'($urandom_range(0, 511));
        pb = ($urandom_range(0, 3) == 0);
        sm = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        gm = 9'h000;
        gc = 0;
        if ($urandom_range(0, 1) == 1) begin
          gm = 9'd1 << $urandom_range(0, nbits[inst] - 1);
          gc = int'($urandom_range(H + 1, H - 1));
        end
        exp_q.push_back(model_entry(inst, d, pb, sm));
        send_frame(inst, d, pb, sm, gm, gc, int'($urandom_range(0, 6)));
      end
      wait_got(inst, 8, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL random_timeout: inst %0d got %0d entries, required 8", inst, got_size(inst)); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = pop_got(inst);
        tests++;
        if (g !== e) begin fails++; $display("FAIL random_entry: inst %0d got %h, required %h", inst, g, e); end
      end
      tests++;
      if (ovr_cnt[inst] != 0 && inst != 0) begin
        fails++; $display("FAIL random_overrun: inst %0d got %0d pulses, required 0", inst, ovr_cnt[inst]);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    rdy_c = 1'b1;
    test_reset();
    test_parity();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable UART receiver with framing options, majority-vote sampling and error reporting. It deserialises 5–9 data bits with optional odd/even parity and 1 or 2 stop bits, and flags parity, framing and overrun errors. Received frames go into an internal show-ahead FIFO drained through a valid/ready handshake. It sits between the board RX pin and the image-data loader, replacing the fixed 8N1 receiver wherever back-pressure or error detection is needed.

## Interface
- CLKS_PER_BIT, 87, i_Clock cycles per UART bit; must be ≥ 8
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, ≥ 2
- i_Clock  input  1  sole clock; all logic on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Serial  input  1  asynchronous serial line, idle high
- o_Rx_Valid  output  1  FIFO non-empty; head entry presented
- i_Rx_Ready  input  1  consumer accepts head entry when o_Rx_Valid=1
- o_Rx_Data  output  DATA_BITS  head entry data
- o_Parity_Err  output  1  head entry parity mismatch; 0 when PARITY=0
- o_Frame_Err  output  1  head entry had a stop bit sampled 0
- o_Overrun  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full

## Operation
- Input path: 2-flop synchroniser. Both flops reset to 1. All FSM decisions use the second flop (rxs).
- Bit timing: counter cnt, width $clog2(CLKS_PER_BIT), runs 0..CLKS_PER_BIT-1 per bit. H = CLKS_PER_BIT/2.
- Sampling: rxs is sampled at cnt = H-1, H and H+1. The bit value is the majority of the three samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: cnt=0, bit index=0. If rxs=0, go to START with cnt=1.
  - START: at cnt=H+1, if the majority is 1 the start is false; return to IDLE. Otherwise continue to cnt=CLKS_PER_BIT-1, then go to DATA with cnt=0.
  - DATA: at the end of each bit, store the majority into shift position idx. After DATA_BITS bits, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: one full bit period.
    - Expected parity bit = ^data for even, ~^data for odd.
    - Mismatch sets the frame's parity_err.
  - STOP: with STOP_BITS=2, the first stop bit runs a full period and the second ends at cnt=H+1. With STOP_BITS=1, the single stop bit ends at cnt=H+1.
    - frame_err = OR of the inverted majorities of all stop bits.
    - At the final decision cycle, push the frame and return to IDLE.
    - Ending at H+1 allows a back-to-back start edge to be detected.
- Frames with errors are still pushed. A break (all-zero data, stop=0) is reported as data 0 with o_Frame_Err=1.
- FIFO entry = {frame_err, parity_err, data}.
  - Push at frame completion.
  - If full and no pop occurs this cycle, the frame is dropped and o_Overrun pulses for 1 cycle.
  - Push and pop in the same cycle while full: push is accepted and occupancy is unchanged.
- Pop when o_Rx_Valid & i_Rx_Ready. Outputs are the head entry, valid whenever the FIFO is non-empty.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide. The extra MSB distinguishes full from empty, and pointers wrap naturally.

## Timing
- Reset (asynchronous assert): FSM=IDLE, cnt=0, FIFO empty.
  - o_Rx_Valid=0, o_Rx_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Overrun=0.
  - Synchroniser flops=1.
- Reset mid-frame discards the partial frame and all FIFO contents. After deassert, reception restarts only on a new falling edge.
- Input latency: 2 cycles from i_Rx_Serial to rxs.
- Push latency: o_Rx_Valid rises the cycle after the push edge (the final stop decision).
- Pop: the head advances on the edge where valid & ready are both 1. Next-entry data is visible in the following cycle.
- i_Rx_Ready has no effect while o_Rx_Valid=0.
- o_Overrun is high for exactly the cycle after the dropped push.
- Line glitches: any low pulse shorter than H-1 cycles in IDLE/START is rejected as a false start. A single-cycle glitch at any sample point is corrected by the majority vote.

## Structure
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - a function computing counter width from CLKS_PER_BIT
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty, same clock/reset. Instantiated with WIDTH=DATA_BITS+2.
- Top module holds the synchroniser, counter, majority voter, shift register and FSM.

## Test plan
All tests use CLKS_PER_BIT=16 unless noted.
1. DATA_BITS=8, PARITY=2, STOP_BITS=1, i_Rx_Ready=1. Send 0xA5 with parity bit 0 → one valid cycle with o_Rx_Data=0xA5, Parity_Err=0, Frame_Err=0.
2. Same configuration. Send 0xA5 with parity bit 1 → 0xA5 with Parity_Err=1. Then send 0x3C with stop bit 0 → 0x3C with Frame_Err=1.
3. DATA_BITS=7, PARITY=1, STOP_BITS=2. Send 0x55 with 1-cycle low glitches at sample H of bits 0 and 3 → 0x55, no errors. A 4-cycle low pulse on the idle line → no frame.
4. FIFO_DEPTH=2, i_Rx_Ready=0. Send 0x01, 0x02, 0x03 back-to-back → o_Overrun pulses once after the third frame. Then raise ready → pops 0x01 then 0x02, after which o_Rx_Valid=0.
5. Assert i_Reset during data bit 4 of 0xFF with one entry queued → all outputs 0 asynchronously, FIFO empty. A following 0x81 is received correctly.
6. DATA_BITS=9, PARITY=0. Send 0x1F0 followed immediately by 0x00F → both received in order with no errors, confirming the back-to-back start edge is detected.
